// File: rtl/alu_datapath.sv
// A/G operand-result datapath: A loads from BUS on Ain, G captures the ALU result on Gin, G drives out when Gout is high.
// Optional status flags {Z,N,C,V} are built only when ALU_FLAGS_EN is defined; otherwise FLAGS is tied to zero.
module alu_datapath #(
    parameter int WIDTH = 10,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] BUS,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    input  logic [3:0]       ALUcont,
    output logic [WIDTH-1:0] G_DATA,
    output logic             G_OE,
    output logic [WIDTH-1:0] A_Q,
    output logic             OP_ERR,
    output logic [3:0]       FLAGS
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_NEG = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;
    localparam logic [3:0] OP_ASR = 4'b1011;

    // Strobes are single-cycle commands with no handshake: any combination is accepted on any edge.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] res_d;
    logic             op_err_q;
    logic             op_ok;
    logic [SHW-1:0]   sh;

    logic [WIDTH-1:0] add_r;
    logic [WIDTH-1:0] sub_r;
    logic [WIDTH-1:0] shl_r;
    logic [WIDTH-1:0] shr_r;
    logic [WIDTH-1:0] sar_r;

    assign sh    = BUS[SHW-1:0];
    assign op_ok = (ALUcont >= OP_ADD) && (ALUcont <= OP_ASR);

`ifdef ALU_FLAGS_EN
    logic c_add;
    logic brw_sub;
    logic c_shl;
    logic c_shr;
    logic c_sar;

    // One extra bit on the far side of each shift catches the last bit shifted out.
    assign {c_add, add_r}   = {1'b0, a_q} + {1'b0, BUS};
    assign {brw_sub, sub_r} = {1'b0, a_q} - {1'b0, BUS};
    assign {c_shl, shl_r}   = {1'b0, a_q} << sh;
    assign {shr_r, c_shr}   = {a_q, 1'b0} >> sh;
    assign {sar_r, c_sar}   = $signed({a_q, 1'b0}) >>> sh;
`else
    assign add_r = a_q + BUS;
    assign sub_r = a_q - BUS;
    assign shl_r = a_q << sh;
    assign shr_r = a_q >> sh;
    assign sar_r = $signed(a_q) >>> sh;
`endif

    always_comb begin
        res_d = '0;
        case (ALUcont)
            OP_ADD:  res_d = add_r;
            OP_SUB:  res_d = sub_r;
            OP_NEG:  res_d = -BUS;
            OP_NOT:  res_d = ~BUS;
            OP_AND:  res_d = a_q & BUS;
            OP_OR:   res_d = a_q | BUS;
            OP_XOR:  res_d = a_q ^ BUS;
            OP_LSL:  res_d = shl_r;
            OP_LSR:  res_d = shr_r;
            OP_ASR:  res_d = sar_r;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
        end else if (Ain) begin
            a_q <= BUS;
        end
    end

    // R is built from the pre-edge A, so a same-cycle Ain does not affect the captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q      <= '0;
            op_err_q <= 1'b0;
        end else begin
            op_err_q <= Gin && !op_ok;
            if (Gin && op_ok) begin
                g_q <= res_d;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic       c_flag;
    logic       v_flag;
    logic [3:0] flags_d;
    logic [3:0] flags_q;

    always_comb begin
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (ALUcont)
            OP_ADD: begin
                c_flag = c_add;
                v_flag = (a_q[WIDTH-1] == BUS[WIDTH-1]) && (add_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                c_flag = !brw_sub;
                v_flag = (a_q[WIDTH-1] != BUS[WIDTH-1]) && (sub_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_NEG:  v_flag = (BUS == {1'b1, {(WIDTH-1){1'b0}}});
            OP_LSL:  c_flag = c_shl;
            OP_LSR:  c_flag = c_shr;
            OP_ASR:  c_flag = c_sar;
            default: begin
                c_flag = 1'b0;
                v_flag = 1'b0;
            end
        endcase
        flags_d = {(res_d == '0), res_d[WIDTH-1], c_flag, v_flag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (Gin && op_ok) begin
            flags_q <= flags_d;
        end
    end

    assign FLAGS = flags_q;
`else
    assign FLAGS = 4'b0000;
`endif

    assign G_OE   = Gout;
    assign G_DATA = Gout ? g_q : '0;
    assign A_Q    = a_q;
    assign OP_ERR = op_err_q;

endmodule

// File: doc/alu_datapath.md
Name: alu_datapath

Overview:
- Arithmetic stage directly downstream of the instruction controller.
- Consumes the controller's Ain, Gin, Gout and ALUcont strobes together with the shared 10-bit data bus.
- Holds the A operand register and the G result register, and computes all two-operand and one-operand data operations.
- Drives G back toward the bus/register file when Gout is asserted.

Parameters:
- WIDTH, 10, data/bus width in bits.
- SHW, 4, number of bus LSBs used as the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- BUS  input  WIDTH  shared data bus (register-file read data or external data).
- Ain  input  1  load A from BUS at the next edge.
- Gin  input  1  load G with the ALU result at the next edge.
- Gout  input  1  request G on the output.
- ALUcont  input  4  operation select, same encoding as the instruction low nibble.
- G_DATA  output  WIDTH  G register value when G_OE=1, else 0.
- G_OE  output  1  output enable toward the bus mux (equals Gout, combinational).
- A_Q  output  WIDTH  current A register (debug/observe).
- OP_ERR  output  1  registered one-cycle pulse: Gin with an unsupported ALUcont.
- FLAGS  output  4  {Z,N,C,V}; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous): A=0, G=0, OP_ERR=0, FLAGS=0. G_DATA=0; G_OE follows Gout, so it is 0 when Gout=0. Reset mid-operation discards any pending load.
- A register: if Ain=1 at the rising edge, A<=BUS; otherwise A holds.
- Result R is combinational from the current A, BUS and ALUcont, with B=BUS:
  - 0010 add: A+B.
  - 0011 sub: A-B.
  - 0100 negate: -B (two's complement).
  - 0101 not: ~B.
  - 0110 and: A&B.
  - 0111 or: A|B.
  - 1000 xor: A^B.
  - 1001 lsl: A<<B[SHW-1:0].
  - 1010 lsr: A>>B[SHW-1:0].
  - 1011 asr: A>>>B[SHW-1:0].
  - All arithmetic is modulo 2^WIDTH.
- Shift amounts >= WIDTH: lsl/lsr give 0; asr gives all bits = A[WIDTH-1]. A shift of 0 gives A unchanged.
- G register: if Gin=1 and ALUcont is supported, G<=R at the edge. Latency is one cycle: the result is visible on G_DATA in the cycle after Gin.
- Unsupported ALUcont (0000, 0001, 1100-1111) with Gin=1: G and FLAGS hold; OP_ERR=1 for exactly the next cycle. OP_ERR is 0 in all other cycles.
- Simultaneous Ain and Gin: R uses the old A (pre-edge); A takes BUS at the same edge.
- Simultaneous Gin and Gout: G_DATA shows the old G in that cycle; the new G appears the following cycle.
- Gout is purely combinational gating with no state. G is never modified by Gout.
- No internal state machine beyond the registers. The controller's timestep T sequences the strobes, and this block accepts any strobe pattern on any cycle.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: FLAGS is a registered 4-bit status, updated only on a supported Gin, from R and the operands:
  - Z = (R==0).
  - N = R[WIDTH-1].
  - C for add = carry out; C for sub = NOT borrow (A>=B unsigned); C for lsl = last bit shifted out; C for lsr/asr = last bit shifted out; shift 0 gives C=0; other ops give C=0.
  - V for add/sub = signed overflow; V for negate = (B==10'h200); V for other ops = 0.
  - FLAGS resets to 0.
- Not defined: FLAGS is tied to 4'b0000 and no flag logic or registers are synthesized. All other behaviour is identical.

Test Plan:
- Reset, then BUS=10'h005 with Ain, then BUS=10'h003 with Gin and ALUcont=0010, then Gout -> G_DATA=10'h008, G_OE=1; with ALU_FLAGS_EN, FLAGS=0000.
- A=10'h3FF, BUS=10'h001, add -> G=10'h000; with flags, Z=1, C=1, V=0. Then sub with A=10'h000, B=10'h001 -> G=10'h3FF, N=1, C=0.
- A=10'h200, asr by 3 -> G=10'h3C0. lsr by 3 -> 10'h040. lsl by 12 -> 10'h000. asr by 15 -> 10'h3FF.
- Same-cycle Ain (BUS=10'h010) and Gin xor with A=10'h0F0 -> G=10'h0F0^10'h010=10'h0E0, A=10'h010 afterwards. Gin and Gout in the same cycle -> old G on G_DATA.
- Gin with ALUcont=1110 while G=10'h123 -> G stays 10'h123, OP_ERR high for exactly one cycle, FLAGS unchanged.
- Assert rst_n=0 between clock edges while G=10'h155 -> A, G, FLAGS and G_DATA go to 0 immediately without a clock edge. Gout=0 at any time -> G_DATA=0, G_OE=0.
